// File: rtl/hist_frame_ctrl.sv
// Frame sequencer + two-requester arbiter feeding the histogramming core, with indexed bin readout.
// Build option: define HIST_FRAME_CTRL_FIXED_PRIO_EN for fixed req0-first priority instead of round-robin.
module hist_frame_ctrl #(
   parameter int FRAME_LEN = 256,
   parameter int CNT_W     = 16,
   parameter int BIN_IDX_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 req0_valid,
   input  logic [15:0]          req0_data,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [15:0]          req1_data,
   output logic                 req1_ready,
   output logic [15:0]          hist_data_in,
   output logic                 hist_write_en,
   input  logic                 hist_ready,
   input  logic                 hist_valid_out,
   input  logic                 hist_last_bin,
   input  logic [7:0]           hist_data_out,
   output logic                 bin_valid,
   output logic [BIN_IDX_W-1:0] bin_index,
   output logic [7:0]           bin_data,
   output logic                 frame_done,
   output logic [7:0]           frame_count,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, COLLECT, READOUT, DONE} state_t;

   state_t               state;
   logic [CNT_W-1:0]     count;
   logic [15:0]          hold_data;
   logic [BIN_IDX_W-1:0] next_idx;
   logic                 grant_ok;
   logic                 gnt;

`ifdef HIST_FRAME_CTRL_FIXED_PRIO_EN
   assign gnt = ~req0_valid;
`else
   logic last_gnt;
   // On a tie the requester not granted last wins; otherwise the valid one.
   assign gnt = (req0_valid & req1_valid) ? ~last_gnt : ~req0_valid;
`endif

   assign grant_ok      = (state == COLLECT) & enable & hist_ready & (count < CNT_W'(FRAME_LEN));
   assign hist_write_en = grant_ok & (req0_valid | req1_valid);
   assign req0_ready    = grant_ok & ~gnt;
   assign req1_ready    = grant_ok & gnt;
   assign hist_data_in  = hist_write_en ? (gnt ? req1_data : req0_data) : hold_data;
   assign busy          = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         hold_data   <= '0;
         next_idx    <= '0;
         bin_valid   <= 1'b0;
         bin_index   <= '0;
         bin_data    <= '0;
         frame_done  <= 1'b0;
         frame_count <= '0;
`ifndef HIST_FRAME_CTRL_FIXED_PRIO_EN
         last_gnt    <= 1'b1;
`endif
      end else begin
         frame_done <= 1'b0;
         bin_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (enable) begin
                  state <= COLLECT;
                  count <= '0;
               end
            end
            COLLECT: begin
               if (hist_write_en) begin
                  count     <= count + 1'b1;
                  hold_data <= hist_data_in;
`ifndef HIST_FRAME_CTRL_FIXED_PRIO_EN
                  last_gnt  <= gnt;
`endif
                  if (count == CNT_W'(FRAME_LEN - 1)) state <= READOUT;
               end
            end
            READOUT: begin
               if (hist_valid_out) begin
                  bin_valid <= 1'b1;
                  bin_data  <= hist_data_out;
                  bin_index <= next_idx;
                  next_idx  <= next_idx + 1'b1;
                  // Last bin's bin_valid lands together with the frame_done pulse.
                  if (hist_last_bin) begin
                     state       <= DONE;
                     frame_done  <= 1'b1;
                     frame_count <= frame_count + 8'd1;
                  end
               end
            end
            DONE: begin
               next_idx <= '0;
               count    <= '0;
               state    <= enable ? COLLECT : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hist_frame_ctrl.sv
// Self-checking bench for hist_frame_ctrl: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_hist_frame_ctrl;
   localparam int FL = 4;
   localparam int CW = 16;
   localparam int BW = 3;
`ifdef HIST_FRAME_CTRL_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [15:0]   req0_data = '0, req1_data = '0;
   logic          req0_ready, req1_ready;
   logic [15:0]   hist_data_in;
   logic          hist_write_en;
   logic          hist_ready = 1'b0;
   logic          hist_valid_out = 1'b0, hist_last_bin = 1'b0;
   logic [7:0]    hist_data_out = '0;
   logic          bin_valid;
   logic [BW-1:0] bin_index;
   logic [7:0]    bin_data;
   logic          frame_done;
   logic [7:0]    frame_count;
   logic          busy;

   hist_frame_ctrl #(.FRAME_LEN(FL), .CNT_W(CW), .BIN_IDX_W(BW)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .hist_data_in(hist_data_in), .hist_write_en(hist_write_en), .hist_ready(hist_ready),
      .hist_valid_out(hist_valid_out), .hist_last_bin(hist_last_bin), .hist_data_out(hist_data_out),
      .bin_valid(bin_valid), .bin_index(bin_index), .bin_data(bin_data),
      .frame_done(frame_done), .frame_count(frame_count), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase 0=idle 1=collect 2=readout 3=done
   int            m_phase = 0;
   int            m_cnt = 0;
   bit            m_last = 1'b1;
   logic [15:0]   m_hold = '0;
   bit            m_bv = 1'b0, m_fd = 1'b0;
   logic [BW-1:0] m_bidx = '0, m_nidx = '0;
   logic [7:0]    m_bdata = '0, m_fc = '0;
   int            wraps = 0;
   bit            e_ok, e_any, e_win, e_we;
   logic [15:0]   e_dat;

   always @(negedge clk) begin
      e_ok  = (m_phase == 1) && enable && hist_ready && (m_cnt < FL);
      e_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) e_win = FIXED ? 1'b0 : !m_last;
      else                          e_win = !req0_valid;
      e_we  = e_ok && e_any;
      e_dat = e_we ? (e_win ? req1_data : req0_data) : m_hold;
      if (started) begin
         chk("write_en", hist_write_en, e_we);
         chk("data_in", hist_data_in, e_dat);
         if (e_any) begin
            chk("req0_ready", req0_ready, e_ok && !e_win);
            chk("req1_ready", req1_ready, e_ok && e_win);
         end else begin
            chk("ready_noreq", (req0_ready & req1_ready) | (!e_ok & (req0_ready | req1_ready)), 0);
         end
         chk("bin_valid", bin_valid, m_bv);
         if (m_bv) begin
            chk("bin_index", bin_index, m_bidx);
            chk("bin_data", bin_data, m_bdata);
         end
         chk("frame_done", frame_done, m_fd);
         chk("frame_count", frame_count, m_fc);
         chk("busy", busy, m_phase != 0);
      end
      if (reset) begin
         m_phase = 0; m_cnt = 0; m_last = 1'b1; m_hold = '0; m_bv = 0; m_fd = 0;
         m_bidx = '0; m_nidx = '0; m_bdata = '0; m_fc = '0;
      end else begin
         m_fd = 0;
         m_bv = 0;
         case (m_phase)
            0: if (enable) begin m_phase = 1; m_cnt = 0; end
            1: if (e_we) begin
                  m_cnt++;
                  m_last = e_win;
                  m_hold = e_dat;
                  if (m_cnt == FL) m_phase = 2;
               end
            2: if (hist_valid_out) begin
                  m_bv = 1; m_bidx = m_nidx; m_bdata = hist_data_out; m_nidx = m_nidx + 1'b1;
                  if (hist_last_bin) begin
                     m_phase = 3; m_fd = 1;
                     if (m_fc == 8'd255) wraps++;
                     m_fc = m_fc + 8'd1;
                  end
               end
            default: begin m_phase = enable ? 1 : 0; m_cnt = 0; m_nidx = '0; end
         endcase
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   int gseq[$];
   int n;

   initial begin
      // Reset and idle state
      cyc(); cyc();
      reset = 1'b0;
      started = 1'b1;
      smp();
      chk("rst_busy", busy, 0);
      chk("rst_fc", frame_count, 0);
      chk("rst_bv", bin_valid, 0);
      chk("rst_we", hist_write_en, 0);
      chk("rst_din", hist_data_in, 0);

      // Round-robin tie
      cyc();
      enable = 1; req0_valid = 1; req1_valid = 1; hist_ready = 1;
      req0_data = 16'hA000; req1_data = 16'hB000;
      for (int i = 0; i < 8; i++) begin
         smp();
         if (hist_write_en) gseq.push_back(int'(req1_ready));
         cyc();
         req0_data = req0_data + 1'b1;
         req1_data = req1_data + 1'b1;
      end
      chk("rr_count", gseq.size(), 4);
      for (int i = 0; i < gseq.size() && i < 4; i++)
         chk("rr_order", gseq[i], FIXED ? 0 : (i % 2));
      smp();
      chk("ro_req0_ready", req0_ready, 0);
      chk("ro_req1_ready", req1_ready, 0);
      chk("ro_busy", busy, 1);

      // Readout of frame 0
      cyc();
      req0_valid = 0; req1_valid = 0;
      hist_valid_out = 1; hist_data_out = 8'h05;
      cyc();
      hist_data_out = 8'h00;
      smp();
      chk("rd0_idx", bin_index, 0); chk("rd0_dat", bin_data, 8'h05); chk("rd0_fd", frame_done, 0);
      cyc();
      hist_data_out = 8'h09; hist_last_bin = 1;
      smp();
      chk("rd1_idx", bin_index, 1); chk("rd1_dat", bin_data, 8'h00);
      cyc();
      hist_valid_out = 0; hist_last_bin = 0;
      smp();
      chk("rd2_idx", bin_index, 2); chk("rd2_dat", bin_data, 8'h09);
      chk("rd2_fd", frame_done, 1); chk("rd2_fc", frame_count, 1);

      // Backpressure
      cyc();
      req0_valid = 1; req0_data = 16'h1111;
      smp();
      chk("bp_pre_we", hist_write_en, 1); chk("bp_pre_din", hist_data_in, 16'h1111);
      cyc();
      hist_ready = 0; req0_data = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("bp_we", hist_write_en, 0); chk("bp_r0", req0_ready, 0);
         chk("bp_hold", hist_data_in, 16'h1111);
         cyc();
      end
      hist_ready = 1;
      smp();
      chk("bp_we_after", hist_write_en, 1); chk("bp_din", hist_data_in, 16'h1234);
      chk("bp_r0_after", req0_ready, 1);

      // Enable gating after 2 of 4 samples
      cyc();
      enable = 0; req0_valid = 1; req1_valid = 1;
      for (int i = 0; i < 4; i++) begin
         smp();
         chk("gate_we", hist_write_en, 0); chk("gate_busy", busy, 1);
         cyc();
      end
      enable = 1;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         smp();
         if (hist_write_en) n++;
         cyc();
      end
      chk("gate_xfers", n, 2);
      smp();
      chk("gate_ro_busy", busy, 1);
      chk("gate_ro_ready", req0_ready | req1_ready, 0);

      // Bin index wrap, then reset mid-readout
      cyc();
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 10; i++) begin
         hist_valid_out = 1; hist_data_out = 8'(i + 16);
         smp();
         if (i == 8) chk("wrap_idx7", bin_index, 7);
         if (i == 9) begin chk("wrap_idx0", bin_index, 0); chk("wrap_dat", bin_data, 8'd24); end
         cyc();
      end
      hist_valid_out = 0;
      reset = 1;
      cyc();
      reset = 0;
      smp();
      chk("mrst_busy", busy, 0); chk("mrst_fc", frame_count, 0); chk("mrst_bv", bin_valid, 0);
      cyc();
      req0_valid = 1; req1_valid = 1;
      smp();
      chk("mrst_tie_we", hist_write_en, 1);
      chk("mrst_tie_r0", req0_ready, 1); chk("mrst_tie_r1", req1_ready, 0);

      // Randomized traffic until frame_count has wrapped
      n = 0;
      while (n < 40000 && !(wraps > 0 && n >= 6000)) begin
         cyc();
         enable         = ($urandom_range(0, 9) != 0);
         req0_valid     = $urandom_range(0, 1);
         req1_valid     = $urandom_range(0, 1);
         req0_data      = 16'($urandom);
         req1_data      = 16'($urandom);
         hist_ready     = ($urandom_range(0, 3) != 0);
         hist_valid_out = ($urandom_range(0, 3) != 0);
         hist_last_bin  = ($urandom_range(0, 4) == 0);
         hist_data_out  = 8'($urandom);
         reset          = (wraps > 0) && ($urandom_range(0, 299) == 0);
         n++;
      end
      smp();
      chk("fc_wrapped", wraps > 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
